// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush sequencer with EX forwarding, dmem-wait watchdog and stall counter.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_wr_i,
  input  logic             ex_mem_to_reg_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_wr_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_wr_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_ERR = 2'd3;
  logic [1:0]       r_state;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_live, w_act, w_lu, w_mw;
  logic [7:0]       w_ctl;
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] mrd, input logic mwr,
                                         input logic [4:0] wrd, input logic wwr);
    return (mwr && mrd != 5'd0 && mrd == src) ? 2'b10 : (wwr && wrd != 5'd0 && wrd == src) ? 2'b01 : 2'b00;
  endfunction
  assign w_live = r_state != S_IDLE;
  assign w_act  = r_state == S_RUN || r_state == S_WAIT;
  assign w_mw   = dmem_req_i && !dmem_ready_i;
  assign w_lu   = ex_mem_to_reg_i && ex_reg_wr_i && ex_rd_i != 5'd0 &&
                  ((id_use_rs_i && id_rs_i == ex_rd_i) || (id_use_rt_i && id_rt_i == ex_rd_i));
  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
  always_comb w_ctl = !w_act ? 8'h00 : w_mw ? 8'h01 : br_taken_i ? 8'hFE : w_lu ? 8'h3A : 8'hF8;
  assign {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
          if_id_flush_o, id_ex_flush_o, mem_wb_flush_o} = w_ctl;
  assign fwd_a_o     = w_live ? fwd_sel(ex_rs_i, mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i) : 2'b00;
  assign fwd_b_o     = w_live ? fwd_sel(ex_rt_i, mem_rd_i, mem_reg_wr_i, wb_rd_i, wb_reg_wr_i) : 2'b00;
  assign err_o       = r_state == S_ERR;
  assign stall_cnt_o = r_stall_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: if (w_mw) begin
          r_state    <= S_WAIT;
          r_wait_cnt <= 8'd1;
        end
        S_WAIT: if (!w_mw) begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end else if (r_wait_cnt == 8'(TIMEOUT)) r_state <= S_ERR;
        else r_wait_cnt <= r_wait_cnt + 8'd1;
        default: ;
      endcase
      if (w_live && !pc_en_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, hand sequences and random stimulus checked against a rule-level model.
module tb_hazard_ctrl;
  localparam int TO = 16;
  localparam int CW = 16;
  localparam int SMAX = (1 << CW) - 1;
  typedef struct packed {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, ex_wr, ex_m2r, mem_wr, wb_wr, br, req, rdy;
  } in_t;
  typedef struct {
    string      name;
    in_t        in;
    logic [7:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  in_t  in;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, mem_wb_fl, err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [7:0] ctl;
  int checks = 0, errors = 0;
  bit m_started, m_err;
  int m_streak, m_stalls;
  vec_t tbl[$];
  localparam in_t NOP = '0;
  localparam in_t MW  = in_t'{req: 1'b1, default: '0};

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs_i(in.id_rs), .id_rt_i(in.id_rt), .id_use_rs_i(in.id_use_rs), .id_use_rt_i(in.id_use_rt),
    .ex_rs_i(in.ex_rs), .ex_rt_i(in.ex_rt), .ex_rd_i(in.ex_rd),
    .ex_reg_wr_i(in.ex_wr), .ex_mem_to_reg_i(in.ex_m2r),
    .mem_rd_i(in.mem_rd), .mem_reg_wr_i(in.mem_wr), .wb_rd_i(in.wb_rd), .wb_reg_wr_i(in.wb_wr),
    .br_taken_i(in.br), .dmem_req_i(in.req), .dmem_ready_i(in.rdy),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .mem_wb_en_o(mem_wb_en), .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl),
    .mem_wb_flush_o(mem_wb_fl), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .err_o(err), .stall_cnt_o(stall_cnt)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, mem_wb_fl};
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (!reset || !m_started) return 2'b00;
    if (in.mem_wr && in.mem_rd != 0 && in.mem_rd == src) return 2'b10;
    if (in.wb_wr && in.wb_rd != 0 && in.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_mw();
    return in.req && !in.rdy;
  endfunction

  function automatic logic [7:0] m_ctl();
    bit lu;
    lu = in.ex_m2r && in.ex_wr && in.ex_rd != 0 &&
         ((in.id_use_rs && in.id_rs == in.ex_rd) || (in.id_use_rt && in.id_rt == in.ex_rd));
    if (!reset || !m_started || m_err) return 8'h00;
    if (m_mw()) return 8'b00000_001;
    if (in.br) return 8'b11111_110;
    if (lu) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic check_model();
    chk("ctl", ctl, m_ctl());
    chk("fwd_a", fwd_a, m_fwd(in.ex_rs));
    chk("fwd_b", fwd_b, m_fwd(in.ex_rt));
    chk("err", err, m_err);
    chk("stall_cnt", stall_cnt, m_stalls);
  endtask

  task automatic tick();
    if (!reset) return;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (!m_ctl()[7]) m_stalls = (m_stalls == SMAX) ? SMAX : m_stalls + 1;
    if (!m_err) begin
      if (m_mw()) begin
        m_streak++;
        if (m_streak == TO + 1) m_err = 1;
      end else m_streak = 0;
    end
  endtask

  task automatic step(input in_t v);
    @(negedge clk);
    in = v;
    #1 check_model();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    m_started = 0; m_err = 0; m_streak = 0; m_stalls = 0;
    #1 chk("rst_err", err, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_stall", stall_cnt, 0);
    repeat (3) @(negedge clk);
    in = NOP;
    reset = 1'b1;
    #1 check_model();
    chk("first_cycle_pc_en", pc_en, 0);
    tick();
  endtask

  task automatic add(input string n, input in_t i, input logic [7:0] c, input logic [1:0] a, input logic [1:0] b);
    vec_t v;
    v.name = n; v.in = i; v.ctl = c; v.fa = a; v.fb = b;
    tbl.push_back(v);
  endtask

  initial begin
    in = NOP;
    add("nop",       NOP, 8'hF8, 2'b00, 2'b00);
    add("fwd_prio",  in_t'{mem_rd: 7, wb_rd: 7, ex_rt: 7, mem_wr: 1, wb_wr: 1, default: '0}, 8'hF8, 2'b00, 2'b10);
    add("fwd_r0",    in_t'{mem_wr: 1, wb_wr: 1, default: '0}, 8'hF8, 2'b00, 2'b00);
    add("fwd_wb_a",  in_t'{ex_rs: 3, wb_rd: 3, wb_wr: 1, mem_rd: 3, default: '0}, 8'hF8, 2'b01, 2'b00);
    add("fwd_wb_ab", in_t'{ex_rs: 9, ex_rt: 9, mem_rd: 9, wb_rd: 9, wb_wr: 1, default: '0}, 8'hF8, 2'b01, 2'b01);
    add("lu_rt",     in_t'{ex_rd: 4, ex_wr: 1, ex_m2r: 1, id_rt: 4, id_use_rt: 1, default: '0}, 8'h3A, 2'b00, 2'b00);
    add("lu_nouse",  in_t'{ex_rd: 4, ex_wr: 1, ex_m2r: 1, id_rs: 4, default: '0}, 8'hF8, 2'b00, 2'b00);
    add("lu_r0",     in_t'{ex_wr: 1, ex_m2r: 1, id_use_rs: 1, default: '0}, 8'hF8, 2'b00, 2'b00);
    add("br_vs_lu",  in_t'{ex_rd: 6, ex_wr: 1, ex_m2r: 1, id_rs: 6, id_use_rs: 1, br: 1, default: '0}, 8'hFE, 2'b00, 2'b00);
    add("br",        in_t'{br: 1, default: '0}, 8'hFE, 2'b00, 2'b00);
    add("lu_nowr",   in_t'{ex_rd: 4, ex_m2r: 1, id_rs: 4, id_use_rs: 1, default: '0}, 8'hF8, 2'b00, 2'b00);
    add("mem_ready", in_t'{req: 1, rdy: 1, default: '0}, 8'hF8, 2'b00, 2'b00);

    do_reset();
    step(NOP);
    chk("second_cycle_pc_en", pc_en, 1);
    foreach (tbl[k]) begin
      step(tbl[k].in);
      chk({tbl[k].name, "_ctl"}, ctl, tbl[k].ctl);
      chk({tbl[k].name, "_fa"}, fwd_a, tbl[k].fa);
      chk({tbl[k].name, "_fb"}, fwd_b, tbl[k].fb);
    end

    do_reset();
    step(NOP);
    step(in_t'{ex_rd: 5, ex_wr: 1, ex_m2r: 1, id_rs: 5, id_use_rs: 1, default: '0});
    chk("lu_ctl", ctl, 8'h3A);
    step(in_t'{ex_rs: 5, wb_rd: 5, wb_wr: 1, default: '0});
    chk("lu_next_ctl", ctl, 8'hF8);
    chk("lu_next_fwd_a", fwd_a, 2'b01);
    chk("lu_stall_cnt", stall_cnt, 1);

    do_reset();
    step(NOP);
    repeat (4) begin
      step(MW);
      chk("mw_frozen", ctl, 8'h01);
    end
    step(in_t'{req: 1, rdy: 1, br: 1, default: '0});
    chk("mw_release", ctl, 8'hFE);
    chk("mw_stall_cnt", stall_cnt, 4);
    chk("mw_err", err, 0);

    do_reset();
    step(NOP);
    repeat (TO + 1) step(MW);
    chk("wd_before_err", err, 0);
    step(MW);
    chk("wd_err", err, 1);
    step(in_t'{req: 1, rdy: 1, default: '0});
    chk("wd_err_held", err, 1);
    chk("wd_en_held", ctl, 8'h00);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r = '0;
      r.id_rs = 5'($urandom_range(0, 3)); r.id_rt = 5'($urandom_range(0, 3));
      r.ex_rs = 5'($urandom_range(0, 3)); r.ex_rt = 5'($urandom_range(0, 3));
      r.ex_rd = 5'($urandom_range(0, 3)); r.mem_rd = 5'($urandom_range(0, 3));
      r.wb_rd = 5'($urandom_range(0, 3));
      {r.id_use_rs, r.id_use_rt, r.ex_wr, r.ex_m2r, r.mem_wr, r.wb_wr} = 6'($urandom);
      r.br  = $urandom_range(0, 4) == 0;
      r.req = $urandom_range(0, 2) == 0;
      r.rdy = (n % 600) > 560 ? 1'b0 : $urandom_range(0, 3) != 0;
      step(r);
      if (n % 700 == 699) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Drives enable/flush of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits, and supplies EX-stage forwarding selects.
- Includes a memory-wait watchdog and a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 16: max consecutive dmem wait cycles before fatal error (2..255).
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- id_rs_i, id_rt_i  in  5  source regs of instruction in ID.
- id_use_rs_i, id_use_rt_i  in  1  ID instruction reads rs/rt.
- ex_rs_i, ex_rt_i  in  5  source regs of instruction in EX.
- ex_rd_i  in  5  dest reg in EX.
- ex_reg_wr_i, ex_mem_to_reg_i  in  1  EX writes reg / is load.
- mem_rd_i  in  5  dest reg in MEM.
- mem_reg_wr_i  in  1  MEM writes reg.
- wb_rd_i  in  5  dest reg in WB.
- wb_reg_wr_i  in  1  WB writes reg.
- br_taken_i  in  1  branch in EX resolved taken.
- dmem_req_i  in  1  MEM stage accesses data memory (load or store).
- dmem_ready_i  in  1  data memory completes access this cycle.
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1  register load enables.
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1  load bubble (all control bits 0) instead of data.
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 regfile, 10 MEM result, 01 WB result.
- err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_en_o=0.

Behaviour:
- Reset (reset=0, async):
  - All *_en_o=0, all *_flush_o=0, fwd=00, err_o=0, stall_cnt_o=0, state=IDLE, wait_cnt=0.
- States: IDLE, RUN, WAIT, ERR.
  - IDLE → RUN on first clk edge after reset release; in IDLE all outputs keep their reset values.
- Forwarding (combinational; valid in every state except IDLE):
  - fwd_a=10 if mem_reg_wr && mem_rd!=0 && mem_rd==ex_rs.
  - Else fwd_a=01 if wb_reg_wr && wb_rd!=0 && wb_rd==ex_rs.
  - Else fwd_a=00. fwd_b is identical using ex_rt.
  - MEM takes priority over WB.
- Hazard terms:
  - lu = ex_mem_to_reg && ex_reg_wr && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
  - mw = dmem_req && !dmem_ready.
- RUN outputs, evaluated in priority order:
  1. mw: all five enables=0, mem_wb_flush=1 (bubble into WB), other flushes 0. Next state WAIT, wait_cnt=1.
  2. br_taken: all enables=1, if_id_flush=1, id_ex_flush=1. A concurrent lu is ignored because the wrong-path ID instruction is discarded.
  3. lu: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. This is exactly one stall cycle; the load moves to MEM, and forwarding path 10 is not used for a load (the MEM result for loads is delivered via WB forwarding next cycle).
  4. Otherwise: all enables=1, all flushes=0.
- WAIT:
  - While mw=1: same outputs as RUN case 1; wait_cnt increments.
  - If wait_cnt==TIMEOUT and still mw=1: next state ERR.
  - When dmem_ready=1: outputs are evaluated as RUN cases 2-4 in the same cycle; next state RUN; wait_cnt=0.
  - br_taken held during WAIT is applied in the release cycle.
- ERR:
  - All enables=0, all flushes=0, err_o=1.
  - Exit only via reset.
- stall_cnt: +1 on every clk where state!=IDLE and pc_en_o=0. Saturates at all-ones (no wrap).
- Reset asserted mid-WAIT or in ERR: outputs clear immediately (asynchronous); no pending branch or wait is remembered.
- Register $0 never matches for forwarding or load-use.

Test Plan:
- Reset release: reset low 3 cycles, then high → all en=0 during reset and the first cycle; pc_en=1 on cycle 2; stall_cnt=0.
- Load-use: EX lw $5 (ex_mem_to_reg=1, ex_rd=5), ID add using rs=5 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle with WB rd=5 and ex_rs=5 → fwd_a=01; stall_cnt=1.
- Forwarding priority: mem_rd=wb_rd=ex_rt=7, both reg_wr=1 → fwd_b=10; rd=0 in both → fwd_b=00.
- Branch vs load-use: br_taken=1 and lu=1 in the same cycle → all en=1, if_id_flush=id_ex_flush=1, no stall.
- Memory wait: dmem_req=1, dmem_ready low for 4 cycles then high → 4 frozen cycles with mem_wb_flush=1, release on the 5th cycle, stall_cnt=4, err_o=0.
- Watchdog: TIMEOUT=16, dmem_ready held low → ERR entered after 16 wait cycles, err_o=1, all en=0 held; reset low → err_o=0 immediately.
